// File: rtl/ddr3_bclk_train_pkg.sv
// Shared definitions for the DDR3 BCLK training controller.
//   train_state_t   : controller FSM state encoding
//   PAT_A / PAT_B   : the two valid deserialised BCLK words
//   is_bclk_pattern : true when a word is one of the valid BCLK patterns
package ddr3_bclk_train_pkg;

    localparam logic [7:0] PAT_A = 8'h55;
    localparam logic [7:0] PAT_B = 8'hAA;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CLEAR,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EVAL,
        ST_STEP,
        ST_STEP_GAP,
        ST_CENTER,
        ST_CENTER_GAP,
        ST_FAIL_LOAD,
        ST_DONE,
        ST_FAIL
    } train_state_t;

    function automatic logic is_bclk_pattern(input logic [7:0] word);
        return (word == PAT_A) || (word == PAT_B);
    endfunction

endpackage

// File: rtl/ddr3_bclk_training_ctrl_if.sv
// Bundle of the training handshake (to the PHY sequencer) and the IOD lane
// signals (RX data, eye flags, delay-line controls).
//   modport master : sequencer / IOD side (drives start, RX data, flags)
//   modport slave  : the training controller
interface ddr3_bclk_training_ctrl_if #(
    parameter int unsigned TAP_W = 7
);
    logic             TRAIN_START;
    logic             TRAIN_BUSY;
    logic             TRAIN_DONE;
    logic             TRAIN_FAIL;
    logic [TAP_W-1:0] WIN_START;
    logic [TAP_W:0]   WIN_WIDTH;
    logic [TAP_W-1:0] FINAL_TAP;
    logic [7:0]       RX_DATA;
    logic             EYE_MONITOR_EARLY;
    logic             EYE_MONITOR_LATE;
    logic             DELAY_LINE_OUT_OF_RANGE;
    logic             DELAY_LINE_MOVE;
    logic             DELAY_LINE_DIRECTION;
    logic             DELAY_LINE_LOAD;
    logic             EYE_MONITOR_CLEAR_FLAGS;

    modport master (
        output TRAIN_START, RX_DATA, EYE_MONITOR_EARLY, EYE_MONITOR_LATE,
               DELAY_LINE_OUT_OF_RANGE,
        input  TRAIN_BUSY, TRAIN_DONE, TRAIN_FAIL, WIN_START, WIN_WIDTH,
               FINAL_TAP, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
               DELAY_LINE_LOAD, EYE_MONITOR_CLEAR_FLAGS
    );

    modport slave (
        input  TRAIN_START, RX_DATA, EYE_MONITOR_EARLY, EYE_MONITOR_LATE,
               DELAY_LINE_OUT_OF_RANGE,
        output TRAIN_BUSY, TRAIN_DONE, TRAIN_FAIL, WIN_START, WIN_WIDTH,
               FINAL_TAP, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
               DELAY_LINE_LOAD, EYE_MONITOR_CLEAR_FLAGS
    );
endinterface

// File: rtl/ddr3_bclk_window_tracker.sv
// Tracks the current and the best contiguous run of passing taps.
//   clk, rst_n     : clock, synchronous active-low reset
//   clr            : clear all window state (new training run)
//   eval, pass     : one tap verdict per eval pulse, for tap cur_tap
//   best_start/len : registered best window
//   best_*_nxt     : best window including the verdict being presented now,
//                    so the FSM can decide the sweep outcome in the same cycle
module ddr3_bclk_window_tracker #(
    parameter int unsigned TAP_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             eval,
    input  logic             pass,
    input  logic [TAP_W-1:0] cur_tap,
    output logic [TAP_W-1:0] best_start,
    output logic [TAP_W:0]   best_len,
    output logic [TAP_W-1:0] best_start_nxt,
    output logic [TAP_W:0]   best_len_nxt
);
    import ddr3_bclk_train_pkg::*;

    logic [TAP_W-1:0] cur_start;
    logic [TAP_W-1:0] cur_start_nxt;
    logic [TAP_W:0]   cur_len;
    logic [TAP_W:0]   cur_len_nxt;

    always_comb begin
        cur_start_nxt  = cur_start;
        cur_len_nxt    = cur_len;
        best_start_nxt = best_start;
        best_len_nxt   = best_len;
        if (eval) begin
            if (pass) begin
                if (cur_len == '0) begin
                    cur_start_nxt = cur_tap;
                end
                cur_len_nxt = cur_len + (TAP_W+1)'(1);
            end else begin
                cur_len_nxt = '0;
            end
            // Strictly greater: on equal length the earlier window is kept.
            if (cur_len_nxt > best_len) begin
                best_start_nxt = cur_start_nxt;
                best_len_nxt   = cur_len_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cur_start  <= '0;
            cur_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
        end else begin
            cur_start  <= cur_start_nxt;
            cur_len    <= cur_len_nxt;
            best_start <= best_start_nxt;
            best_len   <= best_len_nxt;
        end
    end

endmodule

// File: rtl/ddr3_bclk_training_ctrl.sv
// Fabric-side BCLK training controller. Sweeps the IOD RX delay line from
// tap 0 upward, grades each tap from RX_DATA and the eye-monitor flags,
// finds the widest passing window and parks the line at its centre.
//   FAB_CLK : fabric clock (same as IOD RX_CLK)
//   RESET_N : synchronous active-low reset
//   bus     : training handshake + IOD lane signals (slave side)
module ddr3_bclk_training_ctrl #(
    parameter int unsigned NUM_TAPS   = 128,
    parameter int unsigned TAP_W      = 7,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned SAMPLE_CYC = 16,
    parameter int unsigned MIN_WINDOW = 4
) (
    input logic FAB_CLK,
    input logic RESET_N,
    ddr3_bclk_training_ctrl_if.slave bus
);
    import ddr3_bclk_train_pkg::*;

    localparam int unsigned CNT_MAX = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

    train_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [TAP_W-1:0] cur_tap;
    logic [TAP_W-1:0] centre_tap;
    logic [7:0]       first_word;
    logic             data_ok;
    logic             eye_seen;

    logic             busy_r, done_r, fail_r;
    logic             move_r, dir_r, load_r, clear_r;
    logic [TAP_W-1:0] win_start_r, final_tap_r;
    logic [TAP_W:0]   win_width_r;

    logic             eye_now;
    logic             tap_pass;
    logic             start_accept;
    logic             eval;
    logic [TAP_W-1:0] best_start, best_start_nxt;
    logic [TAP_W:0]   best_len, best_len_nxt;

    assign eye_now      = bus.EYE_MONITOR_EARLY | bus.EYE_MONITOR_LATE;
    assign eval         = (state == ST_EVAL);
    // Flags raised in the EVAL cycle itself still disqualify the tap.
    assign tap_pass     = data_ok & ~eye_seen & ~eye_now & ~bus.DELAY_LINE_OUT_OF_RANGE;
    assign start_accept = bus.TRAIN_START &&
                          (state == ST_IDLE || state == ST_DONE || state == ST_FAIL);

    ddr3_bclk_window_tracker #(
        .TAP_W (TAP_W)
    ) u_tracker (
        .clk            (FAB_CLK),
        .rst_n          (RESET_N),
        .clr            (start_accept),
        .eval           (eval),
        .pass           (tap_pass),
        .cur_tap        (cur_tap),
        .best_start     (best_start),
        .best_len       (best_len),
        .best_start_nxt (best_start_nxt),
        .best_len_nxt   (best_len_nxt)
    );

    always_ff @(posedge FAB_CLK) begin
        if (!RESET_N) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            cur_tap     <= '0;
            centre_tap  <= '0;
            first_word  <= '0;
            data_ok     <= 1'b0;
            eye_seen    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            fail_r      <= 1'b0;
            move_r      <= 1'b0;
            dir_r       <= 1'b0;
            load_r      <= 1'b0;
            clear_r     <= 1'b0;
            win_start_r <= '0;
            win_width_r <= '0;
            final_tap_r <= '0;
        end else begin
            move_r  <= 1'b0;
            load_r  <= 1'b0;
            clear_r <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (start_accept) begin
                        state   <= ST_LOAD;
                        load_r  <= 1'b1;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        fail_r  <= 1'b0;
                        // Up-direction is set here so it is already stable
                        // ahead of every sweep MOVE.
                        dir_r   <= 1'b1;
                        cur_tap <= '0;
                    end
                end
                ST_LOAD: begin
                    state   <= ST_CLEAR;
                    clear_r <= 1'b1;
                end
                ST_CLEAR: begin
                    state    <= ST_SETTLE;
                    cnt      <= '0;
                    eye_seen <= 1'b0;
                end
                ST_SETTLE: begin
                    eye_seen <= eye_seen | eye_now;
                    if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                        state <= ST_SAMPLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    eye_seen <= eye_seen | eye_now;
                    if (cnt == '0) begin
                        first_word <= bus.RX_DATA;
                        data_ok    <= is_bclk_pattern(bus.RX_DATA);
                    end else if (bus.RX_DATA != first_word) begin
                        data_ok <= 1'b0;
                    end
                    if (cnt == CNT_W'(SAMPLE_CYC - 1)) begin
                        state <= ST_EVAL;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_EVAL: begin
                    if (!bus.DELAY_LINE_OUT_OF_RANGE && cur_tap < LAST_TAP) begin
                        state  <= ST_STEP;
                        move_r <= 1'b1;
                    end else if (best_len_nxt < (TAP_W+1)'(MIN_WINDOW)) begin
                        state  <= ST_FAIL_LOAD;
                        load_r <= 1'b1;
                        dir_r  <= 1'b0;
                    end else begin
                        state      <= ST_CENTER;
                        centre_tap <= best_start_nxt + TAP_W'(best_len_nxt >> 1);
                        dir_r      <= 1'b0;
                    end
                end
                ST_STEP: begin
                    state <= ST_STEP_GAP;
                end
                ST_STEP_GAP: begin
                    state   <= ST_CLEAR;
                    cur_tap <= cur_tap + TAP_W'(1);
                    clear_r <= 1'b1;
                end
                ST_CENTER: begin
                    if (cur_tap == centre_tap) begin
                        state       <= ST_DONE;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        win_start_r <= best_start;
                        win_width_r <= best_len;
                        final_tap_r <= cur_tap;
                    end else begin
                        state   <= ST_CENTER_GAP;
                        move_r  <= 1'b1;
                        cur_tap <= cur_tap - TAP_W'(1);
                    end
                end
                ST_CENTER_GAP: begin
                    state <= ST_CENTER;
                end
                ST_FAIL_LOAD: begin
                    state       <= ST_FAIL;
                    cur_tap     <= '0;
                    busy_r      <= 1'b0;
                    fail_r      <= 1'b1;
                    win_start_r <= best_start;
                    win_width_r <= best_len;
                    final_tap_r <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.TRAIN_BUSY              = busy_r;
    assign bus.TRAIN_DONE              = done_r;
    assign bus.TRAIN_FAIL              = fail_r;
    assign bus.WIN_START               = win_start_r;
    assign bus.WIN_WIDTH               = win_width_r;
    assign bus.FINAL_TAP               = final_tap_r;
    assign bus.DELAY_LINE_MOVE         = move_r;
    assign bus.DELAY_LINE_DIRECTION    = dir_r;
    assign bus.DELAY_LINE_LOAD         = load_r;
    assign bus.EYE_MONITOR_CLEAR_FLAGS = clear_r;

endmodule
